// File: rtl/paraleloserie_pkg.sv
// paraleloserie_pkg: constants and the state encoding shared by the
// parallel-to-serial transmitter and its bench.
//   K_IDLE : comma/idle fill symbol
//   SLOTS  : bit slots per byte (one byte every SLOTS clk32f cycles)
//   CNT_W  : width of the slot counter
//   state_t: SYNC (alignment idle run) / RUN (normal operation)
package paraleloserie_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam int         SLOTS  = 8;
  localparam int         CNT_W  = $clog2(SLOTS);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/paraleloserie.sv
// paraleloserie: parallel-to-serial transmitter, MSB first, one bit per
// clk32f cycle. Fills the line with IDLE when nothing is offered, and after
// every reset sends N_SYNC idle bytes before it starts accepting data.
// Ports:
//   clk32f  : bit-rate clock
//   reset   : asynchronous, active-high
//   in      : parallel byte to transmit
//   valid   : in holds a byte to send (hold stable until accepted)
//   ready   : byte is taken on this edge if valid is high
//   out     : serial data, MSB first
//   sending : out carries bits of a data byte (not idle)
module paraleloserie
  import paraleloserie_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] IDLE   = K_IDLE,
  parameter int               N_SYNC = 4
) (
  input  logic             clk32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             valid,
  output logic             ready,
  output logic             out,
  output logic             sending
);

  localparam int SW = $clog2(N_SYNC + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    sync_cnt;
  logic             load;

  // Slot 7 is the load slot: the next edge starts a fresh byte.
  assign load  = (cnt == CNT_W'(SLOTS - 1));
  assign ready = (state == RUN) && load;
  assign out   = sr[WIDTH-1];

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_nx;
  end

  // Leave SYNC on the edge that loads the last idle of the alignment run.
  always_comb begin
    state_nx = state;
    if (state == SYNC && load && sync_cnt == SW'(N_SYNC - 1))
      state_nx = RUN;
  end

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      cnt      <= CNT_W'(SLOTS - 1);
      sync_cnt <= '0;
      sending  <= 1'b0;
    end else if (!load) begin
      sr  <= {sr[WIDTH-2:0], 1'b0};
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
      if (state == RUN && valid) begin
        sr      <= in;
        sending <= 1'b1;
      end else begin
        sr      <= IDLE;
        sending <= 1'b0;
        if (state == SYNC && sync_cnt != SW'(N_SYNC))
          sync_cnt <= sync_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_paraleloserie.sv
// tb_paraleloserie: drives paraleloserie through reset, the idle alignment
// run, single/back-to-back bytes, a late valid, a mid-byte reset, and an
// end-to-end loopback into a small serial receiver that aligns on 0xBC.
// Expected per-cycle {out, sending, ready} are queued as each slot's
// stimulus is planned and popped when the DUT produces that cycle.
module tb_paraleloserie;

  logic       clk32f = 1'b0;
  logic       reset;
  logic [7:0] in_b;
  logic       valid;
  logic       ready, out, sending;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit         v;
    logic [7:0] b;
    bit         o;
    bit         s;
    bit         r;
  } ent_t;

  ent_t       sb[$];
  logic [7:0] rx_got[$];
  logic [7:0] rx_win;
  int         rx_ph;
  bit         rx_al;

  paraleloserie #(.WIDTH(8), .IDLE(8'hBC), .N_SYNC(4)) dut (
    .clk32f (clk32f),
    .reset  (reset),
    .in     (in_b),
    .valid  (valid),
    .ready  (ready),
    .out    (out),
    .sending(sending)
  );

  always #5 clk32f = ~clk32f;

  // Serial receiver: hunts for the comma, then frames every 8 bits and
  // reports non-idle bytes.
  always @(negedge clk32f) begin
    if (reset) begin
      rx_al  = 1'b0;
      rx_win = 8'h00;
      rx_ph  = 0;
    end else begin
      rx_win = {rx_win[6:0], out};
      if (!rx_al) begin
        if (rx_win == 8'hBC) begin
          rx_al = 1'b1;
          rx_ph = 0;
        end
      end else begin
        rx_ph++;
        if (rx_ph == 8) begin
          rx_ph = 0;
          if (rx_win != 8'hBC) rx_got.push_back(rx_win);
        end
      end
    end
  end

  // Plan one 8-cycle slot. valid is high from entry raise_at onward; the
  // byte is accepted only if valid is high at the load edge (entry 0) in RUN.
  task automatic push_slot(input int raise_at, input logic [7:0] b,
                           input bit rdy, input bit run);
    ent_t       e;
    bit         acc;
    logic [7:0] eb;
    acc = run && (raise_at == 0);
    eb  = acc ? b : 8'hBC;
    for (int i = 0; i < 8; i++) begin
      e.v = (i >= raise_at);
      e.b = b;
      e.o = eb[7-i];
      e.s = acc;
      e.r = rdy && (i == 7);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    in_b  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk32f);
      n_cmp++;
      if ({out, ready, sending} !== 3'b000) begin
        n_err++;
        $display("FAIL reset cyc%0d: out/ready/sending=%b required 000", i, {out, ready, sending});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_sync();
    ent_t e;
    int   c = 0;
    // Last alignment slot offers data at the very edge that enters RUN:
    // it must still load idle.
    for (int k = 0; k < 4; k++) push_slot(k == 3 ? 0 : 8, 8'h3C, k == 3, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      valid = e.v; in_b = e.b;
      @(posedge clk32f); @(negedge clk32f);
      n_cmp++;
      if ({out, sending, ready} !== {e.o, e.s, e.r}) begin
        n_err++;
        $display("FAIL sync cyc%0d: out/sending/ready=%b required %b", c, {out, sending, ready}, {e.o, e.s, e.r});
      end
      c++;
    end
  endtask

  task automatic test_single();
    ent_t e;
    int   c = 0;
    push_slot(0, 8'hA5, 1'b1, 1'b1);
    push_slot(8, 8'hA5, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      valid = e.v; in_b = e.b;
      @(posedge clk32f); @(negedge clk32f);
      n_cmp++;
      if ({out, sending, ready} !== {e.o, e.s, e.r}) begin
        n_err++;
        $display("FAIL single cyc%0d: out/sending/ready=%b required %b", c, {out, sending, ready}, {e.o, e.s, e.r});
      end
      c++;
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    int   c = 0;
    int   rdy_n = 0;
    push_slot(0, 8'h00, 1'b1, 1'b1);
    push_slot(0, 8'hFF, 1'b1, 1'b1);
    push_slot(8, 8'h00, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      valid = e.v; in_b = e.b;
      @(posedge clk32f); @(negedge clk32f);
      if (c < 16 && ready) rdy_n++;
      n_cmp++;
      if ({out, sending, ready} !== {e.o, e.s, e.r}) begin
        n_err++;
        $display("FAIL b2b cyc%0d: out/sending/ready=%b required %b", c, {out, sending, ready}, {e.o, e.s, e.r});
      end
      c++;
    end
    n_cmp++;
    if (rdy_n !== 2) begin
      n_err++;
      $display("FAIL b2b ready pulses: got %0d required 2", rdy_n);
    end
  endtask

  task automatic test_mid_valid();
    ent_t e;
    int   c = 0;
    push_slot(4, 8'h5A, 1'b1, 1'b1);  // raised once cnt==3: idle completes
    push_slot(0, 8'h5A, 1'b1, 1'b1);  // taken at the next load slot
    push_slot(8, 8'h5A, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      valid = e.v; in_b = e.b;
      @(posedge clk32f); @(negedge clk32f);
      n_cmp++;
      if ({out, sending, ready} !== {e.o, e.s, e.r}) begin
        n_err++;
        $display("FAIL midvalid cyc%0d: out/sending/ready=%b required %b", c, {out, sending, ready}, {e.o, e.s, e.r});
      end
      c++;
    end
  endtask

  task automatic test_reset_mid();
    ent_t       e;
    int         c = 0;
    logic [7:0] b = 8'hF0;
    valid = 1'b1; in_b = b;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk32f); @(negedge clk32f);
      n_cmp++;
      if ({out, sending, ready} !== {b[7-i], 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL rstmid pre cyc%0d: out/sending/ready=%b required %b", i, {out, sending, ready}, {b[7-i], 2'b10});
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out, sending, ready} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid async: out/sending/ready=%b required 000", {out, sending, ready});
    end
    valid = 1'b0;
    repeat (3) @(negedge clk32f);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) push_slot(8, 8'h00, k == 3, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      valid = e.v; in_b = e.b;
      @(posedge clk32f); @(negedge clk32f);
      n_cmp++;
      if ({out, sending, ready} !== {e.o, e.s, e.r}) begin
        n_err++;
        $display("FAIL rstmid resync cyc%0d: out/sending/ready=%b required %b", c, {out, sending, ready}, {e.o, e.s, e.r});
      end
      c++;
    end
  endtask

  task automatic test_loopback();
    ent_t       e;
    int         c = 0;
    logic [7:0] exp_b[$];
    rx_got.delete();
    push_slot(8, 8'h00, 1'b1, 1'b1);
    push_slot(0, 8'h11, 1'b1, 1'b1); exp_b.push_back(8'h11);
    push_slot(0, 8'h22, 1'b1, 1'b1); exp_b.push_back(8'h22);
    push_slot(0, 8'h33, 1'b1, 1'b1); exp_b.push_back(8'h33);
    push_slot(8, 8'h00, 1'b1, 1'b1);
    push_slot(8, 8'h00, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      valid = e.v; in_b = e.b;
      @(posedge clk32f); @(negedge clk32f);
      n_cmp++;
      if ({out, sending, ready} !== {e.o, e.s, e.r}) begin
        n_err++;
        $display("FAIL loop cyc%0d: out/sending/ready=%b required %b", c, {out, sending, ready}, {e.o, e.s, e.r});
      end
      c++;
    end
    n_cmp++;
    if (rx_al !== 1'b1) begin
      n_err++;
      $display("FAIL loop aligned: got %b required 1", rx_al);
    end
    n_cmp++;
    if (rx_got.size() != exp_b.size()) begin
      n_err++;
      $display("FAIL loop count: got %0d bytes required %0d", rx_got.size(), exp_b.size());
    end
    while (exp_b.size() > 0 && rx_got.size() > 0) begin
      logic [7:0] g, x;
      g = rx_got.pop_front();
      x = exp_b.pop_front();
      n_cmp++;
      if (g !== x) begin
        n_err++;
        $display("FAIL loop byte: got %h required %h", g, x);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sync();
    test_single();
    test_back_to_back();
    test_mid_valid();
    test_reset_mid();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
